// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with BOOT/RUN/STALL(/TRAP) control,
// registered branch flags and link-register write generation.
// Optional feature macro: ALIGN_TRAP_EN (misaligned next-PC traps to 0x80).
module pc_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        pcsrc1,
    input  logic        pcsrc0,
    input  logic        jspal,
    input  logic        balrzwrite,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic [31:0] rtarget,
    input  logic        zin,
    input  logic        nin,
    input  logic        flagwrite,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        zout,
    output logic        nout,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        fetch_valid,
    output logic        trap
);

`ifdef ALIGN_TRAP_EN
    typedef enum logic [1:0] {BOOT, RUN, STALL, TRAP} state_t;
`else
    typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;
`endif

    state_t      state, state_nx;
    logic [31:0] br_off;
    logic [31:0] tgt;
    logic [31:0] pc_nx;
    logic        misal;
    logic        pc_we;
    logic        flag_we;

    assign pc_plus4  = pc + 32'd4;
    assign link_data = pc_plus4;

    // next-PC mux; branch offset is a signed word count
    always_comb begin
        br_off = {{14{imm16[15]}}, imm16, 2'b00};
        tgt    = pc_plus4;
        case ({pcsrc1, pcsrc0})
            2'b00: tgt = pc_plus4;
            2'b01: tgt = pc_plus4 + br_off;
            2'b10: tgt = rtarget;
            2'b11: tgt = {pc_plus4[31:28], jtarget, 2'b00};
            default: tgt = pc_plus4;
        endcase
`ifdef ALIGN_TRAP_EN
        misal = (tgt[1:0] != 2'b00);
        pc_nx = misal ? 32'h0000_0080 : tgt;
`else
        // only rtarget can be misaligned; silently word-align it
        misal = 1'b0;
        pc_nx = tgt & ~32'h3;
`endif
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nx;
    end

    // next state and per-state control/outputs
    always_comb begin
        state_nx    = state;
        pc_we       = 1'b0;
        flag_we     = 1'b0;
        fetch_valid = 1'b0;
        link_we     = 1'b0;
        trap        = 1'b0;
        case (state)
            BOOT: state_nx = RUN;
            RUN: begin
                if (stall) begin
                    state_nx = STALL;
                end else begin
                    fetch_valid = 1'b1;
                    pc_we       = 1'b1;
                    flag_we     = flagwrite;
                    link_we     = (jspal | balrzwrite) & ~misal;
`ifdef ALIGN_TRAP_EN
                    if (misal) state_nx = TRAP;
`endif
                end
            end
            // resuming costs one cycle: no PC update on the exit edge
            STALL: if (!stall) state_nx = RUN;
`ifdef ALIGN_TRAP_EN
            TRAP: begin
                trap = 1'b1;
                if (!stall) state_nx = RUN;
            end
`endif
            default: state_nx = BOOT;
        endcase
    end

    // program counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pc <= 32'h0;
        else if (pc_we) pc <= pc_nx;
    end

    // branch flags; consumers see them one instruction later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zout <= 1'b0;
            nout <= 1'b0;
        end else if (flag_we) begin
            zout <= zin;
            nout <= nin;
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: scoreboard bench for pc_seq. A driver applies directed then
// random stimulus at the falling edge and queues the expected outputs from a
// behavioural model; a monitor pops and compares shortly after each fall.
module tb_pc_seq;
    logic        clk = 1'b0;
    logic        rst_n, stall, pcsrc1, pcsrc0, jspal, balrzwrite;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] rtarget;
    logic        zin, nin, flagwrite;
    logic [31:0] pc, pc_plus4, link_data;
    logic        zout, nout, link_we, fetch_valid, trap;

    pc_seq dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pcsrc1(pcsrc1), .pcsrc0(pcsrc0),
        .jspal(jspal), .balrzwrite(balrzwrite), .imm16(imm16), .jtarget(jtarget),
        .rtarget(rtarget), .zin(zin), .nin(nin), .flagwrite(flagwrite),
        .pc(pc), .pc_plus4(pc_plus4), .zout(zout), .nout(nout), .link_we(link_we),
        .link_data(link_data), .fetch_valid(fetch_valid), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, p4, ld;
        logic        zo, no, lwe, fv, tr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   done = 0;

    // model: mode 0 boot, 1 run, 2 stall, 3 trap
    int          m_mode = 0;
    logic [31:0] m_pc = 0;
    logic        m_z = 0, m_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic st, input logic [1:0] src,
                       input logic [15:0] imm, input logic [25:0] jt, input logic [31:0] rt,
                       input logic fw, input logic zi, input logic ni,
                       input logic js, input logic bal);
        exp_t        e;
        logic [31:0] p4, tgt;
        bit          mis, go;
        @(negedge clk);
        rst_n = r; stall = st; {pcsrc1, pcsrc0} = src; imm16 = imm; jtarget = jt;
        rtarget = rt; flagwrite = fw; zin = zi; nin = ni; jspal = js; balrzwrite = bal;
        if (!r) begin m_mode = 0; m_pc = 0; m_z = 0; m_n = 0; end
        p4 = m_pc + 32'd4;
        case (src)
            2'd0: tgt = p4;
            2'd1: tgt = p4 + 32'(int'($signed(imm)) * 4);
            2'd2: tgt = rt;
            default: tgt = {p4[31:28], jt, 2'b00};
        endcase
        mis = (tgt % 4) != 0;
`ifndef ALIGN_TRAP_EN
        tgt = tgt - (tgt % 4);
        mis = 0;
`endif
        go    = r && m_mode == 1 && !st;
        e.pc  = m_pc; e.p4 = p4; e.ld = p4; e.zo = m_z; e.no = m_n;
        e.fv  = go; e.tr = (m_mode == 3); e.lwe = go && (js || bal) && !mis;
        q.push_back(e);
        if (r) begin
            case (m_mode)
                0: m_mode = 1;
                1: if (st) m_mode = 2;
                   else begin
                       if (fw) begin m_z = zi; m_n = ni; end
                       if (mis) begin m_pc = 32'h80; m_mode = 3; end
                       else m_pc = tgt;
                   end
                default: if (!st) m_mode = 1;
            endcase
        end
    endtask

    // shorthand for a plain running cycle
    task automatic run(input logic [1:0] src, input logic [31:0] rt);
        cyc(1, 0, src, 16'h0, 26'h0, rt, 0, 0, 0, 0, 0);
    endtask

    // monitor: compare every presented cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_plus4", pc_plus4, e.p4);
                chk("link_data", link_data, e.ld);
                chk("zout", 32'(zout), 32'(e.zo));
                chk("nout", 32'(nout), 32'(e.no));
                chk("link_we", 32'(link_we), 32'(e.lwe));
                chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
                chk("trap", 32'(trap), 32'(e.tr));
            end
        end
    end

    initial begin
        #500000;
        if (!done) begin
            $display("FAIL watchdog expired t=%0t", $time);
            $fatal(1);
        end
    end

    initial begin
        rst_n = 0; stall = 0; pcsrc1 = 0; pcsrc0 = 0; jspal = 0; balrzwrite = 0;
        imm16 = 0; jtarget = 0; rtarget = 0; zin = 0; nin = 0; flagwrite = 0;
        // reset, then sequential fetch 0,0,4,8
        cyc(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 2'd3, 16'hFFFF, 26'h3FFFFFF, 32'hFFFF_FFFF, 1, 1, 1, 1, 1);
        repeat (4) run(2'd0, 0);
        // branch back by one word and jump, both landing on 0x100
        run(2'd2, 32'h100);
        cyc(1, 0, 2'd1, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'd3, 0, 26'h0000040, 0, 0, 0, 0, 0, 0);
        // stall three cycles at 0x20 with link requests present
        run(2'd2, 32'h1C);
        run(2'd0, 0);
        repeat (3) cyc(1, 1, 2'd0, 0, 0, 0, 1, 1, 1, 1, 1);
        repeat (3) run(2'd0, 0);
        // flags written now only show on the following cycle
        cyc(1, 0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(1, 0, 2'd1, 16'h0010, 0, 0, 1, 0, 1, 0, 0);
        run(2'd0, 0);
        // both link sources at once; then misaligned register target
        cyc(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 0, 2'd2, 0, 0, 32'h102, 0, 0, 0, 1, 0);
        cyc(1, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) run(2'd0, 0);
        // wrap at top of address space
        run(2'd2, 32'hFFFF_FFFC);
        run(2'd0, 0);
        run(2'd0, 0);
        // reset in the middle of a stall at 0x40
        run(2'd2, 32'h40);
        repeat (2) cyc(1, 1, 2'd2, 0, 0, 32'h200, 1, 1, 1, 1, 0);
        cyc(0, 1, 2'd2, 0, 0, 32'h200, 1, 1, 1, 1, 0);
        repeat (3) run(2'd0, 0);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic [31:0] rt;
            rt = $urandom;
            if ($urandom_range(0, 7) != 0) rt[1:0] = 2'b00;
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                2'($urandom_range(0, 3)), 16'($urandom), 26'($urandom), rt,
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        @(negedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
